// File: rtl/regfile_wb_sink_if.sv
// Writeback, operand-read and issue bundle between WB/ID and the register file.
interface regfile_wb_sink_if #(
  parameter int DATA_W = 32
);
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              rs1_re;
  logic [4:0]        rs1_addr;
  logic [DATA_W-1:0] rs1_data;
  logic              rs2_re;
  logic [4:0]        rs2_addr;
  logic [DATA_W-1:0] rs2_data;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              stall;

  // Pipeline side (WB + ID) drives requests and consumes read data / stall.
  modport master (
    output wb_we, wb_rd, wb_data,
    output rs1_re, rs1_addr, rs2_re, rs2_addr,
    output issue_valid, issue_rd,
    input  rs1_data, rs2_data, stall
  );

  // Register file side.
  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  rs1_re, rs1_addr, rs2_re, rs2_addr,
    input  issue_valid, issue_rd,
    output rs1_data, rs2_data, stall
  );
endinterface

// File: rtl/regfile_wb_sink.sv
// Integer register file terminating writeback, with two combinational read
// ports, optional same-cycle WB->read bypass and a per-register pending-write
// scoreboard that stalls ID on RAW/WAW hazards.

// One read port: operand mux plus its RAW hazard term.
module regfile_wb_sink_rdport #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                   rst_i,
  input  logic                   re_i,
  input  logic [4:0]             addr_i,
  input  logic [31:0][DATA_W-1:0] regs_i,
  input  logic [31:0]            busy_i,
  input  logic [31:0]            wclr_i,
  input  logic                   wb_we_i,
  input  logic [4:0]             wb_rd_i,
  input  logic [DATA_W-1:0]      wb_data_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   raw_o
);
  // x0 and disabled reads return zero; a same-cycle writeback wins over the array.
  always_comb begin
    data_o = '0;
    if (!rst_i && re_i && (addr_i != 5'd0)) begin
      if (BYPASS && wb_we_i && (wb_rd_i == addr_i)) data_o = wb_data_i;
      else                                          data_o = regs_i[addr_i];
    end
  end

  // Without bypass the array value is stale during the writeback cycle, so the
  // completing write only releases the hazard when it can be forwarded.
  always_comb begin
    raw_o = re_i && busy_i[addr_i] && !(BYPASS && wclr_i[addr_i]);
  end
endmodule

module regfile_wb_sink #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_sink_if.slave   bus
);
  localparam int NUM_PORTS = 2;

  logic [31:0][DATA_W-1:0]         regs_q;
  logic [31:0]                     busy_q, busy_d;
  logic [31:0]                     wclr;
  logic                            wb_wr;
  logic [NUM_PORTS-1:0]            rd_re;
  logic [NUM_PORTS-1:0][4:0]       rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
  logic [NUM_PORTS-1:0]            raw;
  logic                            waw;
  logic                            stall;
  logic                            fire;

  assign wb_wr   = bus.wb_we && (bus.wb_rd != 5'd0);
  assign rd_re   = {bus.rs2_re, bus.rs1_re};
  assign rd_addr = {bus.rs2_addr, bus.rs1_addr};

  // Decode the writeback into a per-register "producer completes" vector.
  always_comb begin
    wclr = '0;
    if (wb_wr) wclr[bus.wb_rd] = 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    regfile_wb_sink_rdport #(
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
    ) u_rdport (
      .rst_i     (rst),
      .re_i      (rd_re[p]),
      .addr_i    (rd_addr[p]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .wclr_i    (wclr),
      .wb_we_i   (bus.wb_we),
      .wb_rd_i   (bus.wb_rd),
      .wb_data_i (bus.wb_data),
      .data_o    (rd_data[p]),
      .raw_o     (raw[p])
    );
  end

  assign bus.rs1_data = rd_data[0];
  assign bus.rs2_data = rd_data[1];

  // A single busy bit cannot track two outstanding producers, so a second
  // writer to a busy register waits unless the first completes this cycle.
  always_comb begin
    waw   = (bus.issue_rd != 5'd0) && busy_q[bus.issue_rd] && !wclr[bus.issue_rd];
    stall = !rst && bus.issue_valid && ((|raw) || waw);
    fire  = bus.issue_valid && !stall && (bus.issue_rd != 5'd0);
  end

  assign bus.stall = stall;

  // Scoreboard next state: completions clear, a new producer sets (set wins).
  always_comb begin
    busy_d = busy_q & ~wclr;
    if (fire) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; reset drops any writeback or issue in flight.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Architectural register array; x0 is never written and stays zero.
  always_ff @(posedge clk) begin
    if (rst)        regs_q <= '0;
    else if (wb_wr) regs_q[bus.wb_rd] <= bus.wb_data;
  end
endmodule

// File: tb/tb_regfile_wb_sink.sv
// Bench for regfile_wb_sink: two instances (BYPASS=1 and BYPASS=0) share the
// same stimulus; a directed table, a reset/no-bypass sequence and random
// traffic are checked against an array-based reference model.
module tb_regfile_wb_sink;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          rs1_re, rs2_re;
  logic [4:0]    rs1_addr, rs2_addr;
  logic          issue_valid;
  logic [4:0]    issue_rd;

  regfile_wb_sink_if #(.DATA_W(DW)) bus_a ();
  regfile_wb_sink_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.wb_we = wb_we;             assign bus_b.wb_we = wb_we;
  assign bus_a.wb_rd = wb_rd;             assign bus_b.wb_rd = wb_rd;
  assign bus_a.wb_data = wb_data;         assign bus_b.wb_data = wb_data;
  assign bus_a.rs1_re = rs1_re;           assign bus_b.rs1_re = rs1_re;
  assign bus_a.rs1_addr = rs1_addr;       assign bus_b.rs1_addr = rs1_addr;
  assign bus_a.rs2_re = rs2_re;           assign bus_b.rs2_re = rs2_re;
  assign bus_a.rs2_addr = rs2_addr;       assign bus_b.rs2_addr = rs2_addr;
  assign bus_a.issue_valid = issue_valid; assign bus_b.issue_valid = issue_valid;
  assign bus_a.issue_rd = issue_rd;       assign bus_b.issue_rd = issue_rd;

  regfile_wb_sink #(.DATA_W(DW), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  regfile_wb_sink #(.DATA_W(DW), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, index 0 = bypass instance, 1 = no-bypass instance.
  logic [DW-1:0] m_regs [2][32];
  bit            m_busy [2][32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_wclr(input logic [4:0] i);
    return wb_we && (wb_rd == i) && (i != 5'd0);
  endfunction

  function automatic logic [DW-1:0] m_read(input int c, input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return '0;
    if (c == 0 && wb_we && wb_rd == a) return wb_data;
    return m_regs[c][a];
  endfunction

  function automatic bit m_stall(input int c);
    bit byp, r1, r2, w;
    if (rst || !issue_valid) return 1'b0;
    byp = (c == 0);
    r1  = rs1_re && m_busy[c][rs1_addr] && !(byp && m_wclr(rs1_addr));
    r2  = rs2_re && m_busy[c][rs2_addr] && !(byp && m_wclr(rs2_addr));
    w   = (issue_rd != 5'd0) && m_busy[c][issue_rd] && !m_wclr(issue_rd);
    return r1 || r2 || w;
  endfunction

  task automatic m_edge();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin m_regs[c][i] = '0; m_busy[c][i] = 1'b0; end
      end else begin
        bit s;
        s = m_stall(c);
        if (wb_we && wb_rd != 5'd0) begin
          m_regs[c][wb_rd] = wb_data;
          m_busy[c][wb_rd] = 1'b0;
        end
        if (issue_valid && !s && issue_rd != 5'd0) m_busy[c][issue_rd] = 1'b1;
      end
    end
  endtask

  // Compare both instances with the model, then advance one clock.
  task automatic cycle(input string tag);
    chk({tag, ".a.rs1"},   bus_a.rs1_data, m_read(0, rs1_re, rs1_addr));
    chk({tag, ".a.rs2"},   bus_a.rs2_data, m_read(0, rs2_re, rs2_addr));
    chk({tag, ".a.stall"}, 32'(bus_a.stall), 32'(m_stall(0)));
    chk({tag, ".b.rs1"},   bus_b.rs1_data, m_read(1, rs1_re, rs1_addr));
    chk({tag, ".b.rs2"},   bus_b.rs2_data, m_read(1, rs2_re, rs2_addr));
    chk({tag, ".b.stall"}, 32'(bus_b.stall), 32'(m_stall(1)));
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    rs1_re = 1'b0; rs1_addr = '0; rs2_re = 1'b0; rs2_addr = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  typedef struct {
    bit            rst, we;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    bit            re1;
    logic [4:0]    a1;
    bit            re2;
    logic [4:0]    a2;
    bit            iv;
    logic [4:0]    ird;
    logic [DW-1:0] e1, e2;
    bit            es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit we, input logic [4:0] rd, input logic [DW-1:0] d,
                              input bit re1, input logic [4:0] a1, input bit re2, input logic [4:0] a2,
                              input bit iv, input logic [4:0] ird,
                              input logic [DW-1:0] e1, input logic [DW-1:0] e2, input bit es);
    vec_t v;
    v.rst = r; v.we = we; v.rd = rd; v.data = d; v.re1 = re1; v.a1 = a1; v.re2 = re2; v.a2 = a2;
    v.iv = iv; v.ird = ird; v.e1 = e1; v.e2 = e2; v.es = es;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin m_regs[c][i] = '0; m_busy[c][i] = 1'b0; end

    // Expected outputs below are for the BYPASS=1 instance.
    //              rst   we    rd     data          re1   a1     re2   a2     iv    ird    e1            e2            es
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 32'hDEAD,     1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7,  1'b1, 5'd3,  1'b0, 5'd0,  32'hA5A5A5A5, 32'h12345678, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  1'b1, 5'd3,  1'b0, 5'd0,  32'hA5A5A5A5, 32'h12345678, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd4,  32'h0,        32'h0,        1'b0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,      1'b1, 5'd4,  1'b0, 5'd0,  1'b1, 5'd10, 32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 5'd4, 32'h55,       1'b1, 5'd4,  1'b0, 5'd0,  1'b1, 5'd10, 32'h55,       32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 5'd0,  32'h55,       32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd9,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd9,  32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 5'd9, 32'h99,       1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd9,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  1'b1, 5'd0,  32'h99,       32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 5'd12, 32'hCAFE,    1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd0,  32'hCAFE,     32'hCAFE,     1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd12, 32'hCAFE,     32'hCAFE,     1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd0,  32'hCAFE,     32'hCAFE,     1'b1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; wb_we = tbl[i].we; wb_rd = tbl[i].rd; wb_data = tbl[i].data;
      rs1_re = tbl[i].re1; rs1_addr = tbl[i].a1; rs2_re = tbl[i].re2; rs2_addr = tbl[i].a2;
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      #2;
      chk($sformatf("tbl%0d.rs1", i),   bus_a.rs1_data, tbl[i].e1);
      chk($sformatf("tbl%0d.rs2", i),   bus_a.rs2_data, tbl[i].e2);
      chk($sformatf("tbl%0d.stall", i), 32'(bus_a.stall), 32'(tbl[i].es));
      cycle($sformatf("tbl%0d", i));
    end

    // Reset with busy registers, a writeback and an issue all in flight.
    idle(); rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h777;
    issue_valid = 1'b1; issue_rd = 5'd20; #2;
    chk("rst.stall", 32'(bus_a.stall), 32'h0);
    cycle("rst");
    idle(); rs1_re = 1'b1; rs1_addr = 5'd3; rs2_re = 1'b1; rs2_addr = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd5; #2;
    chk("postrst.rs1", bus_a.rs1_data, 32'h0);
    chk("postrst.a.stall", 32'(bus_a.stall), 32'h0);
    chk("postrst.b.stall", 32'(bus_b.stall), 32'h0);
    cycle("postrst");

    // Without bypass, the RAW stall holds through the writeback cycle.
    idle(); issue_valid = 1'b1; issue_rd = 5'd6; #2;
    cycle("nb.issue");
    idle(); wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    rs1_re = 1'b1; rs1_addr = 5'd6; issue_valid = 1'b1; #2;
    chk("nb.wb.a.rs1",   bus_a.rs1_data, 32'h66);
    chk("nb.wb.a.stall", 32'(bus_a.stall), 32'h0);
    chk("nb.wb.b.rs1",   bus_b.rs1_data, 32'h0);
    chk("nb.wb.b.stall", 32'(bus_b.stall), 32'h1);
    cycle("nb.wb");
    idle(); rs1_re = 1'b1; rs1_addr = 5'd6; issue_valid = 1'b1; #2;
    chk("nb.after.b.rs1",   bus_b.rs1_data, 32'h66);
    chk("nb.after.b.stall", 32'(bus_b.stall), 32'h0);
    cycle("nb.after");

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      wb_we       = ($urandom_range(0, 2) != 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      rs1_re      = ($urandom_range(0, 3) != 0);
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_re      = ($urandom_range(0, 3) != 0);
      rs2_addr    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      #2;
      cycle($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sink.md
Name: regfile_wb_sink

Overview:
- Integer register file that terminates the writeback interface: it accepts destination address/data from the WB stage and serves two read ports to ID.
- Adds a per-register pending-write scoreboard, set at issue and cleared at writeback, so ID stalls on RAW/WAW hazards instead of reading stale values.
- Write-to-read bypass removes the extra cycle when writeback and operand read hit the same register in the same cycle.

Parameters:
- DATA_W, 32, register width in bits.
- BYPASS, 1, 1 = same-cycle WB data forwarded to read ports; 0 = read returns array contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_we  in  1  writeback valid.
- wb_rd  in  5  writeback destination register index.
- wb_data  in  DATA_W  writeback data.
- rs1_re  in  1  read-port 1 enable.
- rs1_addr  in  5  read-port 1 index.
- rs1_data  out  DATA_W  read-port 1 data (combinational).
- rs2_re  in  1  read-port 2 enable.
- rs2_addr  in  5  read-port 2 index.
- rs2_data  out  DATA_W  read-port 2 data (combinational).
- issue_valid  in  1  ID requests issue of an instruction this cycle.
- issue_rd  in  5  destination of issuing instruction (0 = no destination).
- stall  out  1  issue blocked this cycle by a hazard (combinational).

Behaviour:
- State: regs[0..31] DATA_W bits; busy[0..31] 1 bit.
- Reset, synchronous:
  - On a clock edge with rst=1: all regs <= 0, all busy <= 0.
  - rst overrides any simultaneous write or issue; a writeback in flight during reset is dropped.
  - While rst=1: rs1_data=0, rs2_data=0, stall=0.
- Register x0:
  - Writes with wb_rd=0 are ignored.
  - Reads of index 0 return 0.
  - busy[0] is permanently 0; issue_rd=0 never sets it.
- Write:
  - Rising edge with wb_we=1 and wb_rd!=0: regs[wb_rd] <= wb_data.
  - Architectural latency: 1 cycle; visible from the array on the next cycle.
- Read, per port p, combinational, in priority order:
  - rs_p_re=0 or rs_p_addr=0 -> 0.
  - Else BYPASS=1, wb_we=1 and wb_rd==rs_p_addr -> wb_data.
  - Else regs[rs_p_addr].
  - Both ports may address the same register; each returns the same value.
- Write clear (wclr[i]):
  - wclr[i] = wb_we && wb_rd==i && i!=0.
- Hazard detect, combinational, in this order:
  - raw1 = rs1_re && busy[rs1_addr] && !wclr[rs1_addr].
  - raw2 = rs2_re && busy[rs2_addr] && !wclr[rs2_addr].
  - waw = issue_rd!=0 && busy[issue_rd] && !wclr[issue_rd]. A single busy bit per register cannot track two outstanding producers.
  - stall = issue_valid && (raw1 || raw2 || waw).
  - With BYPASS=0, the wclr terms are omitted from raw1/raw2: stall holds until the cycle after writeback.
- Issue fire:
  - fire = issue_valid && !stall && issue_rd!=0.
- Scoreboard update, rising edge, rst=0:
  - wclr[i] -> busy[i] <= 0.
  - fire -> busy[issue_rd] <= 1.
  - Same index cleared and set in one cycle -> set wins, busy stays 1 (new producer replaces completed one).
- Writeback to a non-busy register is legal: it updates regs and leaves busy at 0.
- No internal FSM beyond busy bits. Stall persists cycle-by-cycle until the producer's writeback; ID holds its inputs stable while stalled.

Test Plan:
- Reset then read: assert rst 1 cycle with wb_we=1, wb_rd=5, wb_data=0xDEAD -> after release, rs1_addr=5 reads 0 and all busy are 0.
- x0 protection: wb_we=1, wb_rd=0, wb_data=0xFFFFFFFF; next cycle rs1_addr=0, rs1_re=1 -> rs1_data=0; issue_rd=0 never stalls a following issue.
- Basic write/read and bypass: write x3=0x12345678; next cycle rs2_addr=3 -> 0x12345678; same cycle wb_rd=7, wb_data=0xA5A5A5A5 with rs1_addr=7 -> rs1_data=0xA5A5A5A5 (BYPASS=1), or old value with BYPASS=0.
- RAW stall: issue rd=4; next cycle issue with rs1_addr=4 -> stall=1; hold 3 cycles; writeback x4=0x55 -> stall=0 that same cycle, rs1_data=0x55, issue proceeds.
- WAW and simultaneous set/clear: busy[9]=1; issue_rd=9 -> stall=1; in the writeback cycle of x9, issue with rd=9 fires -> busy[9] remains 1 and a subsequent read of x9 stalls.
- Dual-port same register: rs1_addr=rs2_addr=12 with regs[12]=0xCAFE and busy[12]=0 -> both outputs 0xCAFE, stall=0; with busy[12]=1 -> stall=1.
